skeleton_math_dot: RTL and testbench
====================================

// Module: skeleton_math_dot
// PURPOSE
// - Parametrised successor of the single-cycle signed-multiplier skeleton: on-device test harness for signed vector math.
// - Two modes: MULT (A[0]*B[0], 1 MAC cycle) and DOT (sum A[i]*B[i], i=0..N-1, sequential MAC, N cycles).
// - Sits behind the skeleton bus (ADR/DATA_IN/DATA_OUT/RnW); host loads operands, triggers, polls RDY, reads result.
// PARAMETERS
// - BITWIDTH_IN    8   operand width, signed two's complement (2..16)
// - SIZE_INPUT     8   vector length N (1..63); 2N+3 <= 2**BITWIDTH_ADR
// - BITWIDTH_ADR   6   address width
// - BITWIDTH_SYS   16  bus data width (>= BITWIDTH_IN)
// - BITWIDTH_HEAD  32  metadata width
// - (local) BITWIDTH_ACC = 2*BITWIDTH_IN + clog2(N)  accumulator width; must be <= 2*BITWIDTH_SYS
// PORTS
// - CLK_SYS          in   1                  system clock
// - nRST             in   1                  asynchronous reset, active low
// - EN               in   1                  block enable; low = synchronous clear
// - TRGG_START_CALC  in   1                  start pulse
// - RnW              in   1                  1 = read, 0 = write
// - ADR              in   BITWIDTH_ADR       register address
// - DATA_IN          in   BITWIDTH_SYS       write data
// - DATA_OUT         out  BITWIDTH_SYS       read data (combinational from ADR)
// - DATA_HEAD        out  BITWIDTH_HEAD-6    {4'd2, N[5:0], 6'd2, BITWIDTH_IN[4:0], BITWIDTH_ACC[4:0]}
// - RDY              out  1                  1 = idle; 0 = calculation running
// BEHAVIOUR
// - Map: 0..N-1 = A[i]; N..2N-1 = B[i]; 2N = RES_HI; 2N+1 = RES_LO; 2N+2 = CTRL (bit0 MODE: 0 MULT, 1 DOT).
// - Write (RnW=0, RDY=1): operand <= DATA_IN[BITWIDTH_SYS-1 -: BITWIDTH_IN]; CTRL <= DATA_IN[0]. RES and unmapped addresses are read-only.
// - Read: operands left-aligned, low bits zero; RES_HI/RES_LO = result sign-extended to 2*BITWIDTH_SYS; CTRL = {0.., MODE}; unmapped = 0.
// - nRST low (async): all operands, MODE, result, accumulator, counters = 0; state IDLE; RDY=1; DATA_OUT=0 at every address.
// - EN low: same clear, synchronously at next edge; aborts any run, result = 0.
// - Start: TRGG_START_CALC&&EN registered (1-cycle delay); accepted only in IDLE; triggers while busy are dropped (not queued).
// - FSM: IDLE -> LOAD (acc=0, idx=0, latch A[0]/B[0] into pipe regs) -> MAC (acc += pipeA*pipeB, idx++, latch next pair) -> DONE (result <= acc) -> IDLE.
// - MAC cycles K: MULT = 1, DOT = N; MAC -> DONE when idx == K-1.
// - Timing: trigger sampled at edge t; RDY=0 from t+1; RDY=1 again at t+3+K; result valid when RDY returns 1.
// - RDY = (state == IDLE). Writes while RDY=0 are ignored; reads allowed and return the previous result until DONE.
// - Arithmetic: signed BITWIDTH_IN x BITWIDTH_IN -> 2*BITWIDTH_IN product, sign-extended to BITWIDTH_ACC; no overflow possible.
// - MODE sampled in LOAD; a MODE write while busy is ignored.
// - N=1: DOT identical to MULT (K=1).
// CONFIGURATION
// - Macro SKELETON_MATH_DOT_SAT_EN.
// - Defined: result saturated to signed BITWIDTH_SYS range [-2**(SYS-1), 2**(SYS-1)-1]; RES_HI = saturated value, RES_LO = 0; DATA_HEAD[4:0] = BITWIDTH_SYS.
// - Undefined: full-precision result as above; no saturation logic is synthesised.
// TESTING
// - Reset: nRST=0 mid-DOT run -> RDY=1 immediately; RES_HI=RES_LO=0; all operand reads 0.
// - MULT: A0=0xFD00 (-3), B0=0x0500 (5), MODE=0, trigger -> RDY low exactly 3 cycles; RES_HI=0xFFFF, RES_LO=0xFFF1.
// - DOT N=8: all A=B=0x7F00 (127), MODE=1 -> RDY low 10 cycles; RES_HI=0x0001, RES_LO=0xF808 (129032); with SAT_EN: RES_HI=0x7FFF, RES_LO=0.
// - DOT extremes: all A=B=0x8000 (-128) -> 0x0002_0000; A=-128, B=127 -> 0xFFFE_0400 (-130048); with SAT_EN: 0x7FFF / 0x8000.
// - Busy protection: during DOT run, write A0=0x0100, toggle MODE, pulse trigger -> result unchanged vs undisturbed run; exactly one busy window; A0 readback still holds the old value.
// - EN=0 for 1 cycle, 3 cycles into a run -> RDY=1 next cycle; result=0; MODE=0; operands cleared.

Source files
------------

// File: rtl/skeleton_math_dot_if.sv
// Skeleton bus interface for skeleton_math_dot.
// Carries the register bus (RnW/ADR/DATA_IN/DATA_OUT) and the start/ready handshake.
//   master : host side, drives TRGG_START_CALC, RnW, ADR, DATA_IN; observes DATA_OUT, RDY
//   slave  : block side, drives DATA_OUT, RDY
interface skeleton_math_dot_if #(
    parameter int unsigned BITWIDTH_ADR = 6,
    parameter int unsigned BITWIDTH_SYS = 16
) ();
    logic                    TRGG_START_CALC;
    logic                    RnW;
    logic [BITWIDTH_ADR-1:0] ADR;
    logic [BITWIDTH_SYS-1:0] DATA_IN;
    logic [BITWIDTH_SYS-1:0] DATA_OUT;
    logic                    RDY;

    modport master (
        output TRGG_START_CALC, RnW, ADR, DATA_IN,
        input  DATA_OUT, RDY
    );

    modport slave (
        input  TRGG_START_CALC, RnW, ADR, DATA_IN,
        output DATA_OUT, RDY
    );
endinterface

// File: rtl/skeleton_math_dot.sv
// Signed vector math test harness behind the skeleton bus.
// MULT mode computes A[0]*B[0]; DOT mode computes sum A[i]*B[i] with one MAC per cycle.
// Ports:
//   CLK_SYS   : system clock
//   nRST      : asynchronous reset, active low
//   EN        : block enable, low clears all state at the next edge
//   bus       : skeleton bus + start/ready handshake (slave modport)
//   DATA_HEAD : static metadata {4'd2, N, 6'd2, BITWIDTH_IN, BITWIDTH_ACC or BITWIDTH_SYS}
// Register map: 0..N-1 A[i], N..2N-1 B[i], 2N RES_HI, 2N+1 RES_LO, 2N+2 CTRL (bit0 = DOT mode).
// Build option: define SKELETON_MATH_DOT_SAT_EN to saturate the result to the signed
// BITWIDTH_SYS range (RES_HI = saturated value, RES_LO = 0).
module skeleton_math_dot #(
    parameter int unsigned BITWIDTH_IN   = 8,
    parameter int unsigned SIZE_INPUT    = 8,
    parameter int unsigned BITWIDTH_ADR  = 6,
    parameter int unsigned BITWIDTH_SYS  = 16,
    parameter int unsigned BITWIDTH_HEAD = 32
) (
    input  logic                     CLK_SYS,
    input  logic                     nRST,
    input  logic                     EN,
    skeleton_math_dot_if.slave       bus,
    output logic [BITWIDTH_HEAD-7:0] DATA_HEAD
);
    localparam int unsigned BITWIDTH_ACC = 2 * BITWIDTH_IN + $clog2(SIZE_INPUT);
    localparam int unsigned IdxW         = $clog2(SIZE_INPUT) + 1;
    localparam int          N            = int'(SIZE_INPUT);
    localparam int          AdrResHi     = 2 * N;
    localparam int          AdrResLo     = 2 * N + 1;
    localparam int          AdrCtrl      = 2 * N + 2;

    typedef enum logic [1:0] {StIdle, StLoad, StMac, StDone} state_e;

    state_e                         state_q, state_d;
    logic                           start_q, start_d;
    logic                           mode_q, mode_d;         // host-visible CTRL bit
    logic                           mode_run_q, mode_run_d; // mode captured for the current run
    logic signed [BITWIDTH_IN-1:0]  a_q [SIZE_INPUT];
    logic signed [BITWIDTH_IN-1:0]  a_d [SIZE_INPUT];
    logic signed [BITWIDTH_IN-1:0]  b_q [SIZE_INPUT];
    logic signed [BITWIDTH_IN-1:0]  b_d [SIZE_INPUT];
    logic signed [BITWIDTH_IN-1:0]  pipe_a_q, pipe_a_d, pipe_b_q, pipe_b_d;
    logic signed [BITWIDTH_ACC-1:0] acc_q, acc_d, result_q, result_d;
    logic [IdxW-1:0]                idx_q, idx_d, idx_last;
    logic signed [2*BITWIDTH_IN-1:0]  prod;
    logic signed [2*BITWIDTH_SYS-1:0] res_ext;
    logic [BITWIDTH_IN-1:0]         wr_operand;
    int                             adr;

    assign adr        = int'(bus.ADR);
    assign wr_operand = bus.DATA_IN[BITWIDTH_SYS-1 -: BITWIDTH_IN];
    assign prod       = (2*BITWIDTH_IN)'(pipe_a_q) * (2*BITWIDTH_IN)'(pipe_b_q);
    assign idx_last   = mode_run_q ? IdxW'(SIZE_INPUT - 1) : '0;
    assign res_ext    = (2*BITWIDTH_SYS)'(result_q);
    assign bus.RDY    = (state_q == StIdle);

`ifdef SKELETON_MATH_DOT_SAT_EN
    localparam logic signed [2*BITWIDTH_SYS-1:0] SatMax =
        {{(BITWIDTH_SYS+1){1'b0}}, {(BITWIDTH_SYS-1){1'b1}}};
    localparam logic signed [2*BITWIDTH_SYS-1:0] SatMin = ~SatMax;
    localparam logic [4:0] HeadLow = 5'(BITWIDTH_SYS);
    logic [BITWIDTH_SYS-1:0] res_sat;

    always_comb begin
        if (res_ext > SatMax) begin
            res_sat = SatMax[BITWIDTH_SYS-1:0];
        end else if (res_ext < SatMin) begin
            res_sat = SatMin[BITWIDTH_SYS-1:0];
        end else begin
            res_sat = res_ext[BITWIDTH_SYS-1:0];
        end
    end
`else
    localparam logic [4:0] HeadLow = 5'(BITWIDTH_ACC);
`endif

    assign DATA_HEAD = (BITWIDTH_HEAD-6)'({4'd2, 6'(SIZE_INPUT), 6'd2, 5'(BITWIDTH_IN), HeadLow});

    // Read mux: operands left-aligned on the bus, unmapped addresses read 0.
    always_comb begin
        bus.DATA_OUT = '0;
        for (int i = 0; i < N; i++) begin
            if (adr == i) begin
                bus.DATA_OUT = BITWIDTH_SYS'($unsigned(a_q[i])) << (BITWIDTH_SYS - BITWIDTH_IN);
            end
            if (adr == N + i) begin
                bus.DATA_OUT = BITWIDTH_SYS'($unsigned(b_q[i])) << (BITWIDTH_SYS - BITWIDTH_IN);
            end
        end
`ifdef SKELETON_MATH_DOT_SAT_EN
        if (adr == AdrResHi) bus.DATA_OUT = res_sat;
`else
        if (adr == AdrResHi) bus.DATA_OUT = res_ext[2*BITWIDTH_SYS-1 -: BITWIDTH_SYS];
        if (adr == AdrResLo) bus.DATA_OUT = res_ext[BITWIDTH_SYS-1:0];
`endif
        if (adr == AdrCtrl)  bus.DATA_OUT = BITWIDTH_SYS'(mode_q);
    end

    always_comb begin
        state_d    = state_q;
        start_d    = start_q;
        mode_d     = mode_q;
        mode_run_d = mode_run_q;
        a_d        = a_q;
        b_d        = b_q;
        pipe_a_d   = pipe_a_q;
        pipe_b_d   = pipe_b_q;
        acc_d      = acc_q;
        result_d   = result_q;
        idx_d      = idx_q;

        if (!EN) begin
            state_d    = StIdle;
            start_d    = 1'b0;
            mode_d     = 1'b0;
            mode_run_d = 1'b0;
            pipe_a_d   = '0;
            pipe_b_d   = '0;
            acc_d      = '0;
            result_d   = '0;
            idx_d      = '0;
            for (int i = 0; i < N; i++) begin
                a_d[i] = '0;
                b_d[i] = '0;
            end
        end else begin
            start_d = bus.TRGG_START_CALC;
            unique case (state_q)
                StIdle: begin
                    if (!bus.RnW) begin
                        for (int i = 0; i < N; i++) begin
                            if (adr == i)     a_d[i] = wr_operand;
                            if (adr == N + i) b_d[i] = wr_operand;
                        end
                        if (adr == AdrCtrl) mode_d = bus.DATA_IN[0];
                    end
                    // A start seen while busy is simply overwritten: no queueing.
                    if (start_q) state_d = StLoad;
                end
                StLoad: begin
                    acc_d      = '0;
                    idx_d      = '0;
                    pipe_a_d   = a_q[0];
                    pipe_b_d   = b_q[0];
                    mode_run_d = mode_q;
                    state_d    = StMac;
                end
                StMac: begin
                    acc_d = acc_q + BITWIDTH_ACC'(prod);
                    idx_d = idx_q + IdxW'(1);
                    for (int i = 1; i < N; i++) begin
                        if (int'(idx_q) + 1 == i) begin
                            pipe_a_d = a_q[i];
                            pipe_b_d = b_q[i];
                        end
                    end
                    if (idx_q == idx_last) state_d = StDone;
                end
                StDone: begin
                    result_d = acc_q;
                    state_d  = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK_SYS or negedge nRST) begin
        if (!nRST) begin
            state_q    <= StIdle;
            start_q    <= 1'b0;
            mode_q     <= 1'b0;
            mode_run_q <= 1'b0;
            pipe_a_q   <= '0;
            pipe_b_q   <= '0;
            acc_q      <= '0;
            result_q   <= '0;
            idx_q      <= '0;
            for (int i = 0; i < N; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            mode_q     <= mode_d;
            mode_run_q <= mode_run_d;
            pipe_a_q   <= pipe_a_d;
            pipe_b_q   <= pipe_b_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            idx_q      <= idx_d;
            a_q        <= a_d;
            b_q        <= b_d;
        end
    end
endmodule

// File: tb/tb_skeleton_math_dot.sv
// Directed self-checking bench for skeleton_math_dot (N=8, 8-bit operands, 16-bit bus).
module tb_skeleton_math_dot;
    localparam int unsigned BIN  = 8;
    localparam int unsigned N    = 8;
    localparam int unsigned ADRW = 6;
    localparam int unsigned SYS  = 16;
    localparam int unsigned HEAD = 32;
    localparam int AdrB    = 8;
    localparam int AdrHi   = 16;
    localparam int AdrLo   = 17;
    localparam int AdrCtrl = 18;

`ifdef SKELETON_MATH_DOT_SAT_EN
    localparam logic [15:0] ExpMulHi = 16'hFFF1, ExpMulLo = 16'h0000;
    localparam logic [15:0] ExpPosHi = 16'h7FFF, ExpPosLo = 16'h0000;
    localparam logic [15:0] ExpNnHi  = 16'h7FFF, ExpNnLo  = 16'h0000;
    localparam logic [15:0] ExpNpHi  = 16'h8000, ExpNpLo  = 16'h0000;
    localparam logic [25:0] ExpHead  = {4'd2, 6'd8, 6'd2, 5'd8, 5'd16};
`else
    localparam logic [15:0] ExpMulHi = 16'hFFFF, ExpMulLo = 16'hFFF1;
    localparam logic [15:0] ExpPosHi = 16'h0001, ExpPosLo = 16'hF808;
    localparam logic [15:0] ExpNnHi  = 16'h0002, ExpNnLo  = 16'h0000;
    localparam logic [15:0] ExpNpHi  = 16'hFFFE, ExpNpLo  = 16'h0400;
    localparam logic [25:0] ExpHead  = {4'd2, 6'd8, 6'd2, 5'd8, 5'd19};
`endif

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            en    = 1'b0;
    logic [HEAD-7:0] data_head;
    int              n_checks = 0;
    int              n_errors = 0;
    int              busy, windows;

    skeleton_math_dot_if #(.BITWIDTH_ADR(ADRW), .BITWIDTH_SYS(SYS)) bus_if ();

    skeleton_math_dot #(
        .BITWIDTH_IN  (BIN),
        .SIZE_INPUT   (N),
        .BITWIDTH_ADR (ADRW),
        .BITWIDTH_SYS (SYS),
        .BITWIDTH_HEAD(HEAD)
    ) dut (
        .CLK_SYS  (clk),
        .nRST     (rst_n),
        .EN       (en),
        .bus      (bus_if),
        .DATA_HEAD(data_head)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        @(negedge clk);
        bus_if.RnW     = 1'b0;
        bus_if.ADR     = ADRW'(a);
        bus_if.DATA_IN = d;
        @(negedge clk);
        bus_if.RnW     = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input int a, input logic [15:0] exp);
        @(negedge clk);
        bus_if.ADR = ADRW'(a);
        #1;
        chk(tag, 32'(bus_if.DATA_OUT), 32'(exp));
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] b, input logic mode);
        for (int i = 0; i < int'(N); i++) begin
            wr(i, a);
            wr(AdrB + i, b);
        end
        wr(AdrCtrl, {15'd0, mode});
    endtask

    // Pulses the trigger and watches RDY for 40 cycles; optionally pokes the bus mid-run.
    task automatic run(input bit disturb, output int n_busy, output int n_win);
        bit prev;
        prev   = 1'b1;
        n_busy = 0;
        n_win  = 0;
        @(negedge clk);
        bus_if.TRGG_START_CALC = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (cyc == 0) bus_if.TRGG_START_CALC = 1'b0;
            if (!bus_if.RDY) n_busy++;
            if (prev && !bus_if.RDY) n_win++;
            prev = bus_if.RDY;
            if (disturb) begin
                if (cyc == 3) begin
                    bus_if.RnW = 1'b0; bus_if.ADR = 6'd0; bus_if.DATA_IN = 16'h0100;
                end
                if (cyc == 4) begin
                    bus_if.ADR = ADRW'(AdrCtrl); bus_if.DATA_IN = 16'h0000;
                end
                if (cyc == 5) begin
                    bus_if.RnW = 1'b1; bus_if.TRGG_START_CALC = 1'b1;
                end
                if (cyc == 6) bus_if.TRGG_START_CALC = 1'b0;
            end
        end
    endtask

    initial begin
        bus_if.RnW             = 1'b1;
        bus_if.ADR             = '0;
        bus_if.DATA_IN         = '0;
        bus_if.TRGG_START_CALC = 1'b0;
        #1;
        chk("rst_rdy", 32'(bus_if.RDY), 32'd1);
        chk("head", 32'(data_head), 32'(ExpHead));
        rd_chk("rst_a0", 0, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;

        // MULT: -3 * 5, low operand bits are dropped on write
        wr(0, 16'hFD5A);
        wr(AdrB, 16'h0500);
        wr(AdrCtrl, 16'h0000);
        rd_chk("a0_readback", 0, 16'hFD00);
        rd_chk("b0_readback", AdrB, 16'h0500);
        run(1'b0, busy, windows);
        chk("mul_busy", 32'(busy), 32'd3);
        rd_chk("mul_hi", AdrHi, ExpMulHi);
        rd_chk("mul_lo", AdrLo, ExpMulLo);
        wr(AdrHi, 16'h1234);
        wr(19, 16'hABCD);
        rd_chk("res_ro", AdrHi, ExpMulHi);
        rd_chk("unmapped", 19, 16'h0000);

        // DOT 8 x 127*127
        load(16'h7F00, 16'h7F00, 1'b1);
        rd_chk("ctrl_rd", AdrCtrl, 16'h0001);
        run(1'b0, busy, windows);
        chk("dot_busy", 32'(busy), 32'd10);
        rd_chk("dot_pos_hi", AdrHi, ExpPosHi);
        rd_chk("dot_pos_lo", AdrLo, ExpPosLo);

        // DOT extremes
        load(16'h8000, 16'h8000, 1'b1);
        run(1'b0, busy, windows);
        rd_chk("dot_nn_hi", AdrHi, ExpNnHi);
        rd_chk("dot_nn_lo", AdrLo, ExpNnLo);
        load(16'h8000, 16'h7F00, 1'b1);
        run(1'b0, busy, windows);
        rd_chk("dot_np_hi", AdrHi, ExpNpHi);
        rd_chk("dot_np_lo", AdrLo, ExpNpLo);

        // Busy protection: writes, MODE change and trigger during a run are ignored
        load(16'h7F00, 16'h7F00, 1'b1);
        run(1'b1, busy, windows);
        chk("busy_prot_cycles", 32'(busy), 32'd10);
        chk("busy_prot_windows", 32'(windows), 32'd1);
        rd_chk("busy_prot_hi", AdrHi, ExpPosHi);
        rd_chk("busy_prot_lo", AdrLo, ExpPosLo);
        rd_chk("busy_prot_a0", 0, 16'h7F00);
        rd_chk("busy_prot_ctrl", AdrCtrl, 16'h0001);

        // EN low for one cycle three cycles into a run
        load(16'h1100, 16'h2200, 1'b1);
        @(negedge clk);
        bus_if.TRGG_START_CALC = 1'b1;
        @(negedge clk);
        bus_if.TRGG_START_CALC = 1'b0;
        repeat (3) @(negedge clk);
        chk("en_busy", 32'(bus_if.RDY), 32'd0);
        en = 1'b0;
        @(negedge clk);
        chk("en_clr_rdy", 32'(bus_if.RDY), 32'd1);
        en = 1'b1;
        rd_chk("en_clr_hi", AdrHi, 16'h0000);
        rd_chk("en_clr_lo", AdrLo, 16'h0000);
        rd_chk("en_clr_ctrl", AdrCtrl, 16'h0000);
        rd_chk("en_clr_a0", 0, 16'h0000);
        rd_chk("en_clr_b7", AdrB + 7, 16'h0000);

        // Async reset in the middle of a DOT run
        load(16'h8000, 16'h8000, 1'b1);
        run(1'b0, busy, windows);
        rd_chk("pre_rst_hi", AdrHi, ExpNnHi);
        @(negedge clk);
        bus_if.TRGG_START_CALC = 1'b1;
        @(negedge clk);
        bus_if.TRGG_START_CALC = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mid_busy", 32'(bus_if.RDY), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rdy", 32'(bus_if.RDY), 32'd1);
        rd_chk("rst_mid_hi", AdrHi, 16'h0000);
        rd_chk("rst_mid_lo", AdrLo, 16'h0000);
        rd_chk("rst_mid_a0", 0, 16'h0000);
        rd_chk("rst_mid_b0", AdrB, 16'h0000);
        rd_chk("rst_mid_ctrl", AdrCtrl, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_rdy", 32'(bus_if.RDY), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
